// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus of the operand sequencer: operands/opcode out, result and flags back.
interface alu_operand_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_s;
  logic [N-1:0] alu_result;
  logic         alu_neg;
  logic         alu_zr;
  logic         alu_cry;
  logic         alu_of;

  modport master (
    output alu_a, alu_b, alu_s,
    input  alu_result, alu_neg, alu_zr, alu_cry, alu_of
  );

  modport slave (
    input  alu_a, alu_b, alu_s,
    output alu_result, alu_neg, alu_zr, alu_cry, alu_of
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-stepped operand/opcode entry for a combinational ALU, with a registered result.
// Owns the button synchroniser, the debouncer and the step FSM.
//
//  state  | meaning
//  S_A    | waiting for operand A press
//  S_B    | waiting for operand B press
//  S_OP   | waiting for a legal opcode press (0..9)
//  S_EXEC | one-cycle ALU settle, result captured at its end
//  S_SHOW | result displayed until the next press
module alu_operand_sequencer #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           sw,
  input  logic                   btn_n,
  input  logic                   clr,
  alu_operand_sequencer_if.master alu,
  output logic [N-1:0]           res_q,
  output logic [3:0]             flags_q,
  output logic                   res_valid,
  output logic                   op_err,
  output logic [2:0]             state_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_TC = CW'(DEB_CYCLES - 1);
  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic          btn_meta;
  logic          btn_sync;
  logic          deb_level;
  logic [CW-1:0] deb_cnt;
  logic          press;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [3:0]    s_q, s_d;
  logic [N-1:0]  res_d;
  logic [3:0]    flags_d;
  logic          res_valid_d;
  logic          op_err_d;

  // The level is accepted only after DEB_CYCLES consecutive disagreeing cycles;
  // press fires on the accepted 1->0 edge, so a held button yields one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      deb_level <= 1'b1;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
      press    <= 1'b0;
      if (btn_sync == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TC) begin
        deb_level <= btn_sync;
        deb_cnt   <= '0;
        press     <= deb_level & ~btn_sync;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      res_valid <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      res_valid <= res_valid_d;
      op_err    <= op_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    res_d       = res_q;
    flags_d     = flags_q;
    res_valid_d = res_valid;
    op_err_d    = op_err;

    case (state_q)
      S_A: begin
        if (press) begin
          a_d     = sw;
          state_d = S_B;
        end
      end
      S_B: begin
        if (press) begin
          b_d     = sw;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (press) begin
          if (sw[3:0] <= OP_MAX) begin
            s_d      = sw[3:0];
            op_err_d = 1'b0;
            state_d  = S_EXEC;
          end else begin
            op_err_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        res_d       = alu.alu_result;
        flags_d     = {alu.alu_neg, alu.alu_zr, alu.alu_cry, alu.alu_of};
        res_valid_d = 1'b1;
        state_d     = S_SHOW;
      end
      S_SHOW: begin
        if (press) begin
          res_valid_d = 1'b0;
          state_d     = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    // Soft clear overrides whatever the press would have done this cycle.
    if (clr) begin
      state_d     = S_A;
      a_d         = '0;
      b_d         = '0;
      s_d         = '0;
      res_d       = '0;
      flags_d     = '0;
      res_valid_d = 1'b0;
      op_err_d    = 1'b0;
    end
  end

  assign alu.alu_a = a_q;
  assign alu.alu_b = b_q;
  assign alu.alu_s = s_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: scoreboard of expected results checked on res_valid rise.
module tb_alu_operand_sequencer;
  localparam int N = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic         btn_n;
  logic         clr;
  logic [N-1:0] res_q;
  logic [3:0]   flags_q;
  logic         res_valid;
  logic         op_err;
  logic [2:0]   state_o;

  alu_operand_sequencer_if #(.N(N)) alu_bus ();

  alu_operand_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_n     (btn_n),
    .clr       (clr),
    .alu       (alu_bus),
    .res_q     (res_q),
    .flags_q   (flags_q),
    .res_valid (res_valid),
    .op_err    (op_err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // 4-bit combinational ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A.
  logic [4:0] alu_wide;
  always_comb begin
    alu_wide = {1'b0, alu_bus.alu_a};
    alu_bus.alu_of = 1'b0;
    case (alu_bus.alu_s)
      4'd0: begin
        alu_wide = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b};
        alu_bus.alu_of = (alu_bus.alu_a[3] == alu_bus.alu_b[3]) && (alu_wide[3] != alu_bus.alu_a[3]);
      end
      4'd1: begin
        alu_wide = {1'b0, alu_bus.alu_a} + {1'b0, ~alu_bus.alu_b} + 5'd1;
        alu_bus.alu_of = (alu_bus.alu_a[3] != alu_bus.alu_b[3]) && (alu_wide[3] != alu_bus.alu_a[3]);
      end
      4'd2: alu_wide = {1'b0, alu_bus.alu_a & alu_bus.alu_b};
      4'd3: alu_wide = {1'b0, alu_bus.alu_a | alu_bus.alu_b};
      4'd4: alu_wide = {1'b0, alu_bus.alu_a ^ alu_bus.alu_b};
      default: alu_wide = {1'b0, alu_bus.alu_a};
    endcase
    alu_bus.alu_result = alu_wide[3:0];
    alu_bus.alu_cry    = alu_wide[4];
    alu_bus.alu_neg    = alu_wide[3];
    alu_bus.alu_zr     = (alu_wide[3:0] == 4'd0);
  end

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   flags;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each res_valid rise pop the next expected result.
  logic       prev_valid = 1'b0;
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    if (res_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_res_q", int'(res_q), int'(e.res));
        chk("sb_flags_q", int'(flags_q), int'(e.flags));
        chk("sb_alu_a", int'(alu_bus.alu_a), int'(e.a));
        chk("sb_alu_b", int'(alu_bus.alu_b), int'(e.b));
        chk("sb_alu_s", int'(alu_bus.alu_s), int'(e.s));
        chk("sb_state_show", int'(state_o), 4);
        chk("sb_prev_state_exec", int'(prev_state), 3);
      end
    end
    prev_valid <= res_valid;
    prev_state <= state_o;
  end

  logic watch_b7 = 1'b0;
  logic b7_seen  = 1'b0;
  always @(negedge clk) if (watch_b7 && alu_bus.alu_b == 4'd7) b7_seen <= 1'b1;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [N-1:0] val);
    sw = val;
    btn_n = 1'b0;
    cycles(12);
    btn_n = 1'b1;
    cycles(12);
  endtask

  task automatic push_exp(input logic [N-1:0] r, input logic [3:0] f,
                          input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] s);
    exp_t e;
    e.res = r; e.flags = f; e.a = a; e.b = b; e.s = s;
    exp_q.push_back(e);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes;
    logic [2:0] last_state;
    logic saw_op;

    rst_n = 1'b0; sw = '0; btn_n = 1'b1; clr = 1'b0;
    cycles(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_alu_a", int'(alu_bus.alu_a), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    rst_n = 1'b1;
    cycles(3);

    // Mid-sequence reset
    press(4'd1);
    press(4'd2);
    chk("t1_state_op", int'(state_o), 2);
    rst_n = 1'b0;
    #1;
    chk("t1_state", int'(state_o), 0);
    chk("t1_alu_a", int'(alu_bus.alu_a), 0);
    chk("t1_alu_b", int'(alu_bus.alu_b), 0);
    chk("t1_alu_s", int'(alu_bus.alu_s), 0);
    chk("t1_res_q", int'(res_q), 0);
    chk("t1_flags_q", int'(flags_q), 0);
    chk("t1_res_valid", int'(res_valid), 0);
    chk("t1_op_err", int'(op_err), 0);
    btn_n = 1'b0;
    cycles(5);
    btn_n = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("t1_no_press", int'(state_o), 0);

    // Full add 3 + 5
    press(4'd3);
    press(4'd5);
    chk("t2_alu_a", int'(alu_bus.alu_a), 3);
    chk("t2_alu_b", int'(alu_bus.alu_b), 5);
    push_exp(4'd8, 4'b1001, 4'd3, 4'd5, 4'd0);
    press(4'd0);
    chk("t2_state", int'(state_o), 4);
    chk("t2_res_valid", int'(res_valid), 1);

    // Long hold in S_SHOW
    btn_n = 1'b0;
    changes = 0; last_state = state_o;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state_o != last_state) changes++;
      last_state = state_o;
    end
    btn_n = 1'b1;
    cycles(12);
    chk("t6_single_move", changes, 1);
    chk("t6_state", int'(state_o), 0);
    chk("t6_res_valid", int'(res_valid), 0);
    chk("t6_res_q_kept", int'(res_q), 8);
    chk("t6_flags_kept", int'(flags_q), 9);

    // Bounce then settle low: one press only
    sw = 4'd6;
    changes = 0; last_state = state_o; saw_op = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if (state_o != last_state) changes++;
        if (state_o == 3'd2) saw_op = 1'b1;
        last_state = state_o;
      end
    end
    btn_n = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) btn_n = 1'b1;
      @(negedge clk);
      if (state_o != last_state) changes++;
      if (state_o == 3'd2) saw_op = 1'b1;
      last_state = state_o;
    end
    chk("t3_one_change", changes, 1);
    chk("t3_state", int'(state_o), 1);
    chk("t3_never_op", int'(saw_op), 0);
    chk("t3_alu_a", int'(alu_bus.alu_a), 6);

    // Illegal opcode then legal AND
    press(4'hA);
    chk("t4_state_op", int'(state_o), 2);
    press(4'hC);
    chk("t4_op_err", int'(op_err), 1);
    chk("t4_state_hold", int'(state_o), 2);
    chk("t4_alu_s_hold", int'(alu_bus.alu_s), 0);
    push_exp(4'd2, 4'b0000, 4'd6, 4'hA, 4'd2);
    press(4'h2);
    chk("t4_op_err_clr", int'(op_err), 0);
    chk("t4_alu_s", int'(alu_bus.alu_s), 2);
    press(4'd0);
    chk("t4_back_a", int'(state_o), 0);

    // clr during press in S_B
    press(4'd9);
    chk("t5_state_b", int'(state_o), 1);
    watch_b7 = 1'b1;
    sw = 4'd7;
    clr = 1'b1;
    btn_n = 1'b0;
    cycles(12);
    clr = 1'b0;
    btn_n = 1'b1;
    cycles(12);
    watch_b7 = 1'b0;
    chk("t5_state", int'(state_o), 0);
    chk("t5_alu_a", int'(alu_bus.alu_a), 0);
    chk("t5_alu_b", int'(alu_bus.alu_b), 0);
    chk("t5_res_q", int'(res_q), 0);
    chk("t5_b7_never", int'(b7_seen), 0);

    // Subtract 2 - 5
    press(4'd2);
    press(4'd5);
    push_exp(4'hD, 4'b1000, 4'd2, 4'd5, 4'd1);
    press(4'd1);
    chk("t7_state", int'(state_o), 4);

    cycles(4);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
